// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each granted access takes three cycles: IDLE (grant), ACCESS (strobe), RESP (ack).
module datamem_arbiter #(
   parameter int unsigned NBITS_O = 11,
   parameter int unsigned NBITS_D = 16,
   parameter int unsigned CELDAS  = 10
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req0,
   input  logic               i_req1,
   input  logic               i_we0,
   input  logic               i_we1,
   input  logic [NBITS_O-1:0] i_addr0,
   input  logic [NBITS_O-1:0] i_addr1,
   input  logic [NBITS_D-1:0] i_wdata0,
   input  logic [NBITS_D-1:0] i_wdata1,
   output logic               o_ack0,
   output logic               o_ack1,
   output logic               o_err,
   output logic [NBITS_D-1:0] o_rdata,
   output logic               o_mem_rd,
   output logic               o_mem_wr,
   output logic [NBITS_O-1:0] o_mem_addr,
   output logic [NBITS_D-1:0] o_mem_wdata,
   input  logic [NBITS_D-1:0] i_mem_rdata,
   output logic               o_busy
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e               state_q, state_d;
   logic                 gnt_q;
   logic                 last_q;
   logic                 we_q;
   logic [NBITS_O-1:0]   addr_q;
   logic [NBITS_D-1:0]   wdata_q;
   logic                 err_q;
   logic [NBITS_D-1:0]   rdata_q;
   logic                 any_req;
   logic                 grant;
   logic                 in_range;

   assign any_req  = i_req0 | i_req1;
   // On a tie the requester not served last wins; otherwise the lone requester.
   assign grant    = (i_req0 & i_req1) ? ~last_q : i_req1;
   assign in_range = 32'(addr_q) < CELDAS;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (any_req) state_d = StAccess;
         StAccess: state_d = StResp;
         StResp:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (state_q == StIdle && any_req) begin
            gnt_q   <= grant;
            last_q  <= grant;
            we_q    <= grant ? i_we1 : i_we0;
            addr_q  <= grant ? i_addr1 : i_addr0;
            wdata_q <= grant ? i_wdata1 : i_wdata0;
         end
         if (state_q == StAccess) begin
            err_q <= ~in_range;
            if (!we_q && in_range) rdata_q <= i_mem_rdata;
         end
      end
   end

   always_comb begin
      o_busy      = state_q != StIdle;
      o_mem_rd    = (state_q == StAccess) && in_range && !we_q;
      o_mem_wr    = (state_q == StAccess) && in_range && we_q;
      o_mem_addr  = (o_mem_rd || o_mem_wr) ? addr_q : '0;
      o_mem_wdata = o_mem_wr ? wdata_q : '0;
      o_ack0      = (state_q == StResp) && !gnt_q;
      o_ack1      = (state_q == StResp) && gnt_q;
      o_err       = (state_q == StResp) && err_q;
      o_rdata     = rdata_q;
   end

endmodule

// File: doc/datamem_arbiter.md
DATAMEM_ARBITER -- requirements
Module: datamem_arbiter

Interface
REQ-001 Parameters SHALL be: NBITS_O, default 11, address width; NBITS_D, default 16, data width; CELDAS, default 10, number of valid memory words.
REQ-002 i_clk  in  1  clock; all state updates on the rising edge.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_req0, i_req1  in  1 each  access request from requester 0 / 1; level, held until ack.
REQ-005 i_we0, i_we1  in  1 each  1 = write, 0 = read, valid with the request.
REQ-006 i_addr0, i_addr1  in  NBITS_O each  word address.
REQ-007 i_wdata0, i_wdata1  in  NBITS_D each  write data.
REQ-008 o_ack0, o_ack1  out  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-009 o_err  out  1  valid with an ack pulse; 1 = address out of range, access dropped.
REQ-010 o_rdata  out  NBITS_D  read data, valid in the ack cycle of a read and held until the next read completes.
REQ-011 o_mem_rd, o_mem_wr  out  1 each  memory read / write strobes.
REQ-012 o_mem_addr  out  NBITS_O  memory address.
REQ-013 o_mem_wdata  out  NBITS_D  memory write data.
REQ-014 i_mem_rdata  in  NBITS_D  memory read data, combinational from o_mem_addr while o_mem_rd = 1.
REQ-015 o_busy  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-017 In IDLE, with any request high at a clock edge, the block SHALL select a requester, latch its we/addr/wdata into internal registers, and enter ACCESS.
REQ-018 Arbitration SHALL be round-robin: with both requests high, grant the requester not served last; with one request high, grant it.
REQ-019 After reset the last-served pointer SHALL be 1, so requester 0 wins the first tie.
REQ-020 The last-served pointer SHALL update only on a grant.
REQ-021 In ACCESS, for an in-range address (addr < CELDAS), the block SHALL drive o_mem_addr from the latched address for exactly one cycle.
REQ-022 In that ACCESS cycle, a latched write SHALL assert o_mem_wr with o_mem_wdata = latched wdata; a latched read SHALL assert o_mem_rd.
REQ-023 For a read, i_mem_rdata SHALL be captured into o_rdata at the edge that leaves ACCESS.
REQ-024 For an out-of-range address, ACCESS SHALL assert neither strobe, o_rdata SHALL be unchanged, and the error flag SHALL be latched.
REQ-025 ACCESS SHALL always advance to RESP after one cycle.
REQ-026 In RESP, the ack of the granted requester SHALL be high for exactly one cycle, with o_err valid, then the FSM SHALL return to IDLE.
REQ-027 Outside RESP, both acks SHALL be 0 and o_err SHALL be 0.
REQ-028 Latency SHALL be fixed: a request sampled in IDLE at edge N gives a strobe in cycle N..N+1 and an ack in cycle N+1..N+2.
REQ-029 Throughput SHALL be at most one access per 3 cycles.
REQ-030 Requesters SHALL deassert their request in the cycle after their ack; a request still high when the FSM is in IDLE is a new access.
REQ-031 A request dropped after grant SHALL NOT abort the access; it SHALL complete and be acked.
REQ-032 Input changes after grant SHALL NOT affect the access in flight.
REQ-033 Requests arriving in ACCESS or RESP SHALL wait and SHALL NOT be lost while held.
REQ-034 Both strobes SHALL never be high together, and at most one ack SHALL be high in any cycle.
REQ-035 Address comparison SHALL be unsigned over the full NBITS_O bits.

Reset
REQ-036 With i_reset = 1 at an edge, the block SHALL go to IDLE and set o_ack0, o_ack1, o_err, o_mem_rd, o_mem_wr and o_busy to 0.
REQ-037 Reset SHALL also clear o_mem_addr, o_mem_wdata, o_rdata and the latched registers to 0, and set the pointer to 1.
REQ-038 Reset in ACCESS or RESP SHALL abort the transaction with no ack.
REQ-039 Strobes SHALL be deasserted from the reset edge onward.
REQ-040 Reset SHALL take priority over every other event.

Verification
REQ-041 Read: req0 read, addr 3, memory word 3 = 16'h0003 -> o_mem_rd for 1 cycle with addr 3; ack0 2 cycles after sampling; o_rdata = 16'h0003; o_err = 0.
REQ-042 Write: req1 write, addr 7, data 16'hBEEF -> o_mem_wr for 1 cycle with addr 7 and data BEEF; ack1; a following read of addr 7 by req0 returns 16'hBEEF.
REQ-043 Tie: req0 and req1 held continuously -> grant order 0,1,0,1; acks on cycles 2,5,8,11 after the first sample; each requester's data correct.
REQ-044 Out of range: req0 read addr 10 (CELDAS = 10) -> no strobe; ack0 with o_err = 1; o_rdata unchanged. Addr 2047 gives the same result.
REQ-045 Reset mid-operation: i_reset during ACCESS of a write -> no ack; FSM in IDLE; pointer = 1; the next tie grants requester 0.
REQ-046 Drop after grant: req0 deasserted and addr changed during ACCESS -> the original access completes and ack0 still pulses.
